// File: rtl/traffic_queue_model_if.sv
// Road-side bundle between the traffic-queue model and whatever drives its lights/arrivals.
// Latency: none, wires only.
// Backpressure: none; arrivals are single-cycle pulses and outputs are levels.
//
// Signals:
//   mainLight, countryLight     : 2-bit light codes (00 red, 01 yellow, 10 green, 11 red)
//   main_arrive, country_arrive : one vehicle joins the queue per cycle sampled high
//   main_traffic, country_traffic   : queue occupancy 0..7
//   main_drop_cnt, country_drop_cnt : arrivals lost to a full queue, saturating
//   conflict                    : sticky both-roads-non-red flag
interface traffic_queue_model_if;
  logic [1:0] mainLight;
  logic [1:0] countryLight;
  logic       main_arrive;
  logic       country_arrive;
  logic [2:0] main_traffic;
  logic [2:0] country_traffic;
  logic [7:0] main_drop_cnt;
  logic [7:0] country_drop_cnt;
  logic       conflict;

  // master: the environment driving lights and arrivals
  modport master (
    output mainLight, countryLight, main_arrive, country_arrive,
    input  main_traffic, country_traffic, main_drop_cnt, country_drop_cnt, conflict
  );

  // slave: the queue model itself
  modport slave (
    input  mainLight, countryLight, main_arrive, country_arrive,
    output main_traffic, country_traffic, main_drop_cnt, country_drop_cnt, conflict
  );
endinterface

// File: rtl/traffic_queue_model.sv
// Closed-loop road model: per-road saturating vehicle queues drained at a fixed pace on green.
// Latency: arrivals/departures visible on *_traffic one edge after sampling; first departure
//          DEPART_CYCLES-1 edges after green and a non-empty queue first coincide.
// Backpressure: none; arrivals into a full queue are dropped and counted (saturating at 255).
//
// Ports: clk, reset (sync, active-high), bus (traffic_queue_model_if.slave, see interface file).
module traffic_queue_model #(
  parameter int DEPART_CYCLES = 4   // legal 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  traffic_queue_model_if.slave  bus
);

  localparam int              PCW     = $clog2(DEPART_CYCLES) + 1;
  localparam logic [PCW-1:0]  PC_LAST = PCW'(DEPART_CYCLES - 1);
  localparam logic [1:0]      L_YEL   = 2'b01;
  localparam logic [1:0]      L_GRN   = 2'b10;

  typedef enum logic [1:0] {HOLD, EMPTY, FLOW} state_e;

  // Channel 0 = main road, channel 1 = country road.
  state_e           state_q [2];
  state_e           state_d [2];
  logic [2:0]       q_q     [2];
  logic [2:0]       q_d     [2];
  logic [PCW-1:0]   pc_q    [2];
  logic [PCW-1:0]   pc_d    [2];
  logic [PCW-1:0]   pc_cur  [2];
  logic [7:0]       drop_q  [2];
  logic [7:0]       drop_d  [2];
  logic             dep     [2];
  logic [1:0]       light   [2];
  logic             arr     [2];
  logic             conflict_q;
  logic             conflict_d;
  logic             main_nonred;
  logic             country_nonred;

  assign light[0] = bus.mainLight;
  assign light[1] = bus.countryLight;
  assign arr[0]   = bus.main_arrive;
  assign arr[1]   = bus.country_arrive;

  assign main_nonred    = (bus.mainLight == L_YEL)    || (bus.mainLight == L_GRN);
  assign country_nonred = (bus.countryLight == L_YEL) || (bus.countryLight == L_GRN);

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = HOLD;
      pc_d[ch]    = '0;
      pc_cur[ch]  = '0;
      dep[ch]     = 1'b0;
      q_d[ch]     = q_q[ch];
      drop_d[ch]  = drop_q[ch];

      // Yellow and the reserved code both fall through to HOLD.
      if (light[ch] == L_GRN) begin
        state_d[ch] = (q_q[ch] == 3'd0) ? EMPTY : FLOW;
      end

      if (state_d[ch] == FLOW) begin
        // A pace count only carries over while we stay in FLOW; entering FLOW starts at 0.
        pc_cur[ch] = (state_q[ch] == FLOW) ? pc_q[ch] : '0;
        if (pc_cur[ch] == PC_LAST) begin
          dep[ch] = 1'b1;
        end else begin
          pc_d[ch] = pc_cur[ch] + 1'b1;
        end
      end

      case ({arr[ch], dep[ch]})
        2'b10: begin
          if (q_q[ch] != 3'd7) begin
            q_d[ch] = q_q[ch] + 3'd1;
          end else if (drop_q[ch] != 8'hFF) begin
            drop_d[ch] = drop_q[ch] + 8'd1;
          end
        end
        2'b01:   q_d[ch] = q_q[ch] - 3'd1;   // dep implies q > 0
        default: ;                           // idle, or arrival replaces departure
      endcase
    end

    conflict_d = conflict_q | (main_nonred & country_nonred);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= HOLD;
        q_q[ch]     <= '0;
        pc_q[ch]    <= '0;
        drop_q[ch]  <= '0;
      end
      conflict_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        q_q[ch]     <= q_d[ch];
        pc_q[ch]    <= pc_d[ch];
        drop_q[ch]  <= drop_d[ch];
      end
      conflict_q <= conflict_d;
    end
  end

  assign bus.main_traffic     = q_q[0];
  assign bus.country_traffic  = q_q[1];
  assign bus.main_drop_cnt    = drop_q[0];
  assign bus.country_drop_cnt = drop_q[1];
  assign bus.conflict         = conflict_q;

endmodule
